// File: rtl/mema_ctrl_pkg.sv
// Shared types and sizing helpers for the A-buffer load/stream controller.
package mema_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      STREAM = 2'd2,
      DONE   = 2'd3
   } state_e;

   // Number of enabled stream cycles needed to skew DIM lanes through the array.
   function automatic int STREAM_LEN(input int dim);
      return 2 * dim - 1;
   endfunction

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mema_ctrl_skew_window.sv
// Lane-valid mask: lane i is live while the stream counter lies in [i, i+DIM-1].
module skew_window
   import mema_ctrl_pkg::*;
#(
   parameter int DIM   = 8,
   parameter int CNT_W = 4
) (
   input  logic [CNT_W-1:0] cnt,
   input  logic             en,
   output logic [DIM-1:0]   mask
);

   // Diagonal window per lane, gated by the stream enable.
   always_comb begin
      mask = '0;
      for (int i = 0; i < DIM; i++) begin
         if (en && (int'(cnt) >= i) && (int'(cnt) <= i + DIM - 1)) begin
            mask[i] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mema_ctrl.sv
// Controller that loads DIM rows of A into the buffer, then streams them
// skewed into the array for 2*DIM-1 enabled cycles.
//
//   state  | meaning
//   IDLE   | waiting for start
//   LOAD   | accepting rows 0..DIM-1, one write per in_valid
//   STREAM | shifting the buffer while not stalled
//   DONE   | one-cycle completion pulse, then back to IDLE
module mema_ctrl
   import mema_ctrl_pkg::*;
#(
   parameter int BITS_AB = 8,
   parameter int DIM     = 8
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  start,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   input  logic signed [DIM-1:0][BITS_AB-1:0]    in_data,
   input  logic                                  stall,
   output logic                                  mem_wren,
   output logic [cnt_w(DIM)-1:0]                 mem_arow,
   output logic signed [DIM-1:0][BITS_AB-1:0]    mem_ain,
   output logic                                  mem_en,
   output logic [DIM-1:0]                        lane_valid,
   output logic                                  busy,
   output logic                                  done
);

   localparam int ROW_W = cnt_w(DIM);
   localparam int SLEN  = STREAM_LEN(DIM);
   localparam int CNT_W = cnt_w(SLEN);

   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(DIM - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLEN - 1);

   state_e             state_q, state_d;
   logic [ROW_W-1:0]   row_q, row_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   // State and counter registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         row_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state, counter updates and state-decoded outputs.
   always_comb begin
      state_d  = state_q;
      row_d    = row_q;
      cnt_d    = cnt_q;
      in_ready = 1'b0;
      mem_en   = 1'b0;
      busy     = 1'b1;
      done     = 1'b0;
      case (state_q)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               state_d = LOAD;
               row_d   = '0;
            end
         end
         LOAD: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if (row_q == ROW_LAST) begin
                  // Row counter returns to 0 so mem_arow idles at 0 while streaming.
                  row_d   = '0;
                  cnt_d   = '0;
                  state_d = STREAM;
               end else begin
                  row_d = row_q + 1'b1;
               end
            end
         end
         STREAM: begin
            mem_en = ~stall;
            if (!stall) begin
               if (cnt_q == CNT_LAST) begin
                  state_d = DONE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         DONE: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Buffer write path; in_ready is only high in LOAD so it never overlaps mem_en.
   assign mem_wren = in_valid & in_ready;
   assign mem_ain  = in_data;
   assign mem_arow = row_q;

   skew_window #(
      .DIM   (DIM),
      .CNT_W (CNT_W)
   ) u_skew_window (
      .cnt  (cnt_q),
      .en   (mem_en),
      .mask (lane_valid)
   );

endmodule

// File: doc/mema_ctrl.md
MEMA_CTRL -- requirements
Module: mema_ctrl

Interface
REQ-001 SHALL have parameter BITS_AB, default 8, meaning signed element width of A.
REQ-002 SHALL have parameter DIM, default 8, meaning rows, columns and lanes of A.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  meaning synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  meaning begin a job; sampled only in IDLE.
REQ-006 SHALL have port in_valid  input  1  meaning in_data holds a valid A row.
REQ-007 SHALL have port in_ready  output  1  meaning controller accepts a row this cycle.
REQ-008 SHALL have port in_data  input  DIM x BITS_AB signed  meaning one A row.
REQ-009 SHALL have port stall  input  1  meaning downstream array requests a pause of streaming.
REQ-010 SHALL have port mem_wren  output  1  meaning row-write strobe to the A buffer.
REQ-011 SHALL have port mem_arow  output  clog2(DIM)  meaning row index being written.
REQ-012 SHALL have port mem_ain  output  DIM x BITS_AB signed  meaning row data to the A buffer.
REQ-013 SHALL have port mem_en  output  1  meaning shift/stream enable to the A buffer.
REQ-014 SHALL have port lane_valid  output  DIM  meaning bit i set when lane i carries a real A element.
REQ-015 SHALL have port busy  output  1  meaning job in progress.
REQ-016 SHALL have port done  output  1  meaning one-cycle pulse at job completion.

Function
REQ-017 SHALL implement states IDLE, LOAD, STREAM, DONE.
REQ-018 SHALL in IDLE with start=1 move to LOAD and clear row counter to 0; start in any other state SHALL be ignored.
REQ-019 SHALL drive in_ready=1 only in LOAD.
REQ-020 SHALL drive mem_wren = in_valid & in_ready combinationally, mem_ain = in_data, mem_arow = row counter.
REQ-021 SHALL in LOAD increment the row counter on each accepted row; acceptance of row DIM-1 SHALL move to STREAM with stream counter cleared.
REQ-022 SHALL never assert mem_en and mem_wren in the same cycle.
REQ-023 SHALL in STREAM drive mem_en = ~stall; stream counter increments only when mem_en=1.
REQ-024 SHALL stream exactly 2*DIM-1 enabled cycles; the enabled cycle with counter 2*DIM-2 SHALL move to DONE.
REQ-025 SHALL set lane_valid[i]=1 iff mem_en=1 and i <= counter <= i+DIM-1; otherwise 0.
REQ-026 SHALL in DONE assert done for exactly one cycle, then return to IDLE; start during DONE is ignored.
REQ-027 SHALL drive busy=1 in LOAD, STREAM and DONE; 0 in IDLE.
REQ-028 SHALL hold counters and outputs unchanged across stalled cycles; stall outside STREAM has no effect.
REQ-029 SHALL leave in_valid gaps in LOAD harmless: no write, counter held, no timeout.

Reset
REQ-030 SHALL on rst=1 enter IDLE, clear row and stream counters, giving in_ready=0, mem_wren=0, mem_arow=0, mem_en=0, lane_valid=0, busy=0, done=0 next cycle.
REQ-031 SHALL abort any job when rst asserts mid-LOAD or mid-STREAM; no done pulse is produced for it.

Structure
REQ-032 SHALL place the state enum and STREAM_LEN (2*DIM-1) function in shared package mema_ctrl_pkg.
REQ-033 SHALL implement lane_valid in one sub-module, skew_window, mapping counter and enable to the DIM-bit mask.

Verification (DIM=8)
REQ-034 SHALL cover: start, 8 back-to-back rows -> mem_wren 8 cycles with arow 0..7, then mem_en 15 consecutive cycles, done pulse on cycle 16.
REQ-035 SHALL cover: rows with in_valid gaps of 2 cycles -> exactly 8 writes, arow sequence 0..7 unbroken.
REQ-036 SHALL cover: stall held 3 cycles at stream counter 5 -> mem_en low 3 cycles, total enabled cycles still 15, lane_valid frozen at 0.
REQ-037 SHALL cover: lane_valid check -> counter 0 gives 0x01, counter 7 gives 0xFF, counter 14 gives 0x80.
REQ-038 SHALL cover: rst at stream counter 4 -> all outputs 0 next cycle, no done; fresh start completes normally.
REQ-039 SHALL cover: start pulsed during LOAD and DONE -> ignored, single job and single done observed.
